// File: rtl/pipe_ctrl_pkg.sv
// Shared kind codes, stall vectors and FSM encoding for the pipeline stall controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] MC_NONE = 2'd0;
  localparam logic [1:0] MC_ACC  = 2'd1;
  localparam logic [1:0] MC_DIV  = 2'd2;

  // bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold
  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_FROM_ID = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX = 6'b001111;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACC2     = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DIV_DONE = 2'd3
  } state_t;

  function automatic logic [5:0] stall_merge(input logic flush, input logic ex_stall,
                                             input logic id_stall);
    if (flush)         return STALL_NONE;
    else if (ex_stall) return STALL_FROM_EX;
    else if (id_stall) return STALL_FROM_ID;
    else               return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/multi-cycle requests from the pipeline and the stall/divider controls returned to it.
interface pipe_ctrl_if;

  logic       id_stallreq_i;
  logic       ex_mc_req_i;
  logic [1:0] ex_mc_kind_i;
  logic       div_zero_i;
  logic       div_ready_i;
  logic       flush_i;
  logic [5:0] stall_o;
  logic       div_start_o;
  logic       div_annul_o;
  logic       mc_cycle_o;
  logic       div_done_o;
  logic       div_timeout_o;

  modport master (
    output id_stallreq_i, ex_mc_req_i, ex_mc_kind_i, div_zero_i, div_ready_i, flush_i,
    input  stall_o, div_start_o, div_annul_o, mc_cycle_o, div_done_o, div_timeout_o
  );

  modport slave (
    input  id_stallreq_i, ex_mc_req_i, ex_mc_kind_i, div_zero_i, div_ready_i, flush_i,
    output stall_o, div_start_o, div_annul_o, mc_cycle_o, div_done_o, div_timeout_o
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Merges load-use and EX multi-cycle stalls into a per-stage hold vector, sequences the divider.
// Outputs are same-cycle combinational from state and inputs; no backpressure, divide watchdog-bounded.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_DIV_CYCLES = 40
) (
  input  logic     clk,
  input  logic     rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             w_ex_stall;
  logic             w_start;
  logic             w_annul;
  logic             w_mc;
  logic             w_done;
  logic [5:0]       w_stall;

  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_nxt = r_timeout;
    w_ex_stall    = 1'b0;
    w_start       = 1'b0;
    w_annul       = 1'b0;
    w_mc          = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.ex_mc_req_i) begin
          if (bus.ex_mc_kind_i == MC_ACC) begin
            w_state_nxt = ST_ACC2;
            w_ex_stall  = 1'b1;
          end else if (bus.ex_mc_kind_i == MC_DIV && !bus.div_zero_i) begin
            w_state_nxt = ST_DIV_RUN;
            w_start     = 1'b1;
            w_ex_stall  = 1'b1;
          end
        end
      end
      ST_ACC2: begin
        w_mc        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_DIV_RUN: begin
        w_ex_stall = 1'b1;
        // A result arriving on the last allowed cycle still counts as success.
        if (bus.div_ready_i) begin
          w_state_nxt = ST_DIV_DONE;
        end else if (r_cnt == CNT_LIMIT) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = 1'b1;
          w_annul       = 1'b1;
        end
      end
      ST_DIV_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (bus.flush_i) begin
      w_state_nxt   = ST_IDLE;
      w_start       = 1'b0;
      w_annul       = (r_state == ST_DIV_RUN);
      w_timeout_nxt = r_timeout;
    end

    w_cnt_nxt = (r_state == ST_DIV_RUN && w_state_nxt == ST_DIV_RUN) ? r_cnt + 1'b1 : '0;
    w_stall   = stall_merge(bus.flush_i, w_ex_stall, bus.id_stallreq_i);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Every output is forced low while reset is held, including before the first clock edge.
  assign bus.stall_o       = rst ? w_stall : STALL_NONE;
  assign bus.div_start_o   = rst & w_start;
  assign bus.div_annul_o   = rst & w_annul;
  assign bus.mc_cycle_o    = rst & w_mc;
  assign bus.div_done_o    = rst & w_done;
  assign bus.div_timeout_o = rst & r_timeout;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall and multi-cycle sequencing controller for the 5-stage core. It merges the decode-stage load-use stall request with EX-stage multi-cycle operations (two-cycle accumulate, iterative divide) into one per-stage stall vector. It starts and annuls the external divider and bounds divider latency with a watchdog counter. It sits beside the pipeline registers (pc, if/id, id/ex, ex/mem, mem/wb) and drives their hold enables.

## Interface
- `MAX_DIV_CYCLES`, 40, maximum cycles spent in DIV_RUN before timeout; legal range 2..63.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `id_stallreq_i`  in  1  decode stage requests a stall (load-use hazard).
- `ex_mc_req_i`  in  1  EX holds a valid multi-cycle instruction.
- `ex_mc_kind_i`  in  2  MC_NONE=0, MC_ACC=1 (madd/msub class), MC_DIV=2; 3 reserved, treated as MC_NONE.
- `div_zero_i`  in  1  divisor is zero; the divide completes without running.
- `div_ready_i`  in  1  divider result valid (level, from divider unit).
- `flush_i`  in  1  pipeline flush (exception/annul); highest priority.
- `stall_o`  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold.
- `div_start_o`  out  1  one-cycle pulse that launches the divider.
- `div_annul_o`  out  1  one-cycle pulse that aborts a running divide.
- `mc_cycle_o`  out  1  high in the second cycle of an accumulate op.
- `div_done_o`  out  1  high in the cycle in which EX captures the divide result.
- `div_timeout_o`  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, ACC2, DIV_RUN, DIV_DONE. Encoding lives in the shared defines.
- IDLE:
  - `ex_mc_req_i` with MC_ACC → ACC2; stall EX-and-earlier this cycle.
  - MC_DIV with `div_zero_i`=0 → DIV_RUN, `div_start_o`=1, stall EX-and-earlier.
  - MC_DIV with `div_zero_i`=1 → stay IDLE, no start, no EX stall.
- ACC2: `mc_cycle_o`=1, no EX stall; → IDLE unconditionally.
- DIV_RUN: stall EX-and-earlier; counter increments each cycle.
  - `div_ready_i`=1 → DIV_DONE.
  - Otherwise, counter == MAX_DIV_CYCLES-1 → IDLE, set `div_timeout_o`, pulse `div_annul_o`.
- DIV_DONE: `div_done_o`=1, no EX stall; → IDLE. This state stops the same divide, still in EX, from retriggering.
- The counter (6 bits) clears whenever the block is not in DIV_RUN.
- Stall vector, combinational, in priority order:
  - `flush_i` → 6'b000000.
  - EX stall → 6'b001111.
  - `id_stallreq_i` → 6'b000111.
  - otherwise 6'b000000.
- Flush: from any state, next state is IDLE and the counter clears. If the current state is DIV_RUN, pulse `div_annul_o`. `div_start_o` is suppressed in the flush cycle.
- Simultaneous ID stall and EX stall: the EX vector wins (it is a superset).
- `div_ready_i` and the timeout limit in the same cycle: ready wins, no timeout.

## Timing
- During reset and the cycle after reset release: state IDLE, counter 0, `div_timeout_o`=0. All outputs are 0 while `rst`=0, since combinational outputs are gated by reset.
- `stall_o`, `div_start_o`, `div_annul_o`, `mc_cycle_o`, and `div_done_o` are combinational from state and inputs (same-cycle response). State and counter are registered.
- Accumulate: exactly 1 stall cycle, then 1 cycle with `mc_cycle_o`.
- Divide: start in cycle 0; stall in cycles 0..N, where N is the first DIV_RUN cycle with ready; DIV_DONE in cycle N+1. Total stall is N+1 cycles.
- Timeout aborts after MAX_DIV_CYCLES cycles in DIV_RUN. The flag is visible the cycle after the abort.

## Structure
- Shared `defines.v`:
  - MC_* kind codes.
  - Stall vector constants STALL_NONE, STALL_FROM_ID, STALL_FROM_EX.
  - State encodings.
  - Reset and enable level macros.
- Single module, no sub-module. The watchdog counter is inline (≈150–200 lines of RTL).

## Test plan
- Reset: hold `rst`=0 for 3 cycles with all inputs high → `stall_o`=0 and all pulses 0. After release, `div_timeout_o`=0.
- Load-use: `id_stallreq_i`=1 for 1 cycle in IDLE → `stall_o`=6'b000111 that cycle only.
- Accumulate: req+MC_ACC → cycle 0 `stall_o`=6'b001111; cycle 1 `mc_cycle_o`=1 and `stall_o`=0; cycle 2 IDLE.
- Divide: req+MC_DIV, divisor nonzero, `div_ready_i` rises in the 34th DIV_RUN cycle → one `div_start_o` pulse, 35 stall cycles, one `div_done_o` cycle, no second start.
- Divide by zero: req+MC_DIV with `div_zero_i`=1 → no `div_start_o` and `stall_o`=0.
- Flush and timeout:
  - `flush_i` in DIV_RUN cycle 5 → `div_annul_o` pulse, `stall_o`=0, IDLE next cycle.
  - Separately, ready never arrives → abort after 40 DIV_RUN cycles and `div_timeout_o` stays 1 until reset.
